memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs of the execute stage and accesses a word-addressed internal data RAM, with optional wait states handled by a small FSM. It resolves taken branches and drives the MEM/WB pipeline register. The MEM/WB register feeds write-back and the execute-stage forwarding inputs (ALU_result_MEM, read_data_wb, MemtoReg_MEM).

Parameters:
DEPTH, 256, number of 32-bit words in the data RAM (power of 2)
WAIT_STATES, 0, extra stall cycles per load/store (0..15)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ip_ALU_result  input  32  effective address or ALU result
ip_Add_result  input  8  branch target PC
ip_memory_write_data  input  32  store data
ip_dest_reg  input  5  write-back register
ip_zero  input  1  ALU zero flag
ip_MemtoReg  input  1  write-back select
ip_RegWrite  input  1  write-back enable
ip_read_en  input  1  load
ip_write_en  input  1  store
ip_branch  input  1  branch instruction
op_branch_taken  output  1  ip_branch & ip_zero, combinational; drives the flush and PC select
op_branch_target  output  8  ip_Add_result, combinational
op_stall  output  1  combinational; high while a memory access is waiting
op_read_data  output  32  MEM/WB load data
op_ALU_result  output  32  MEM/WB ALU result
op_dest_reg  output  5  MEM/WB destination
op_MemtoReg  output  1  MEM/WB control
op_RegWrite  output  1  MEM/WB control
op_misaligned  output  1  MEM/WB flag: the access completed this slot had a misaligned address

Behaviour:
- Access: access = ip_read_en | ip_write_en. RAM index = ip_ALU_result[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned: access with ip_ALU_result[1:0] != 0.
  - No RAM write.
  - op_read_data loads 0.
  - op_misaligned = 1 in that result slot.
  - Timing and FSM sequence are unchanged.
- Read and write both asserted: treated as a store. The load data slot captures the pre-write contents (read-before-write).
- FSM states: IDLE and WAIT. The 4-bit counter cnt resets to 0.
  - IDLE, access, WAIT_STATES>0: op_stall=1, go to WAIT, cnt=WAIT_STATES-1.
  - IDLE, access, WAIT_STATES=0: op_stall=0, access completes at this edge.
  - IDLE, no access: op_stall=0.
  - WAIT: op_stall = (cnt!=0).
  - WAIT, cnt!=0: cnt decrements.
  - WAIT, cnt==0: access completes at this edge, go to IDLE.
- Access duration: WAIT_STATES+1 cycles. Upstream holds all ip_* inputs stable while op_stall=1.
- Completing edge:
  - Store: RAM[index] <= ip_memory_write_data.
  - MEM/WB register loads: op_read_data=RAM[index] (0 if misaligned or store-only), op_ALU_result, op_dest_reg, op_MemtoReg, op_RegWrite, op_misaligned.
- Stalled cycles (op_stall=1): MEM/WB loads a bubble (op_RegWrite=0, op_MemtoReg=0, op_misaligned=0; data fields hold). No RAM write.
- Non-access instructions: MEM/WB loads every cycle with op_read_data=0. Latency is 1 cycle from input to MEM/WB output.
- Branches: op_branch_taken is independent of FSM state. Branch instructions never assert op_stall.
- Reset (low, at any time, including mid-WAIT):
  - Immediately forces state=IDLE and cnt=0.
  - All MEM/WB outputs go to 0; op_stall=0.
  - A pending store is abandoned and never written.
  - RAM contents are not reset.
  - After reset release, a held access restarts from IDLE.

Test Plan:
- WAIT_STATES=0: store 0xDEADBEEF to address 0x10, then load 0x10 with MemtoReg=1, RegWrite=1, dest=5 -> next cycle op_read_data=0xDEADBEEF, op_dest_reg=5, op_RegWrite=1, op_stall never high.
- WAIT_STATES=2: load from 0x20 held stable -> op_stall=1 for 2 cycles with bubble outputs (op_RegWrite=0), then data appears 3 cycles after presentation; op_stall=0 in the third cycle.
- Misaligned store to 0x13 with data 0x1234, then aligned load of 0x10 -> old contents unchanged; the store slot shows op_misaligned=1.
- Address wrap, DEPTH=256: store 0x55 to 0x400, load 0x000 -> 0x55.
- ip_branch=1, ip_zero=1, ip_Add_result=0x3C -> same-cycle op_branch_taken=1, op_branch_target=0x3C; with ip_zero=0 -> op_branch_taken=0.
- WAIT_STATES=3: assert reset low during the second WAIT cycle of a store of 0xAAAA to 0x8 -> outputs 0 and op_stall=0 immediately; after release the held load of 0x8 returns prior contents, not 0xAAAA.

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: internal word RAM with optional wait states,
// branch resolution, and the MEM/WB pipeline register.
module memory_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ip_ALU_result,
  input  logic [7:0]  ip_Add_result,
  input  logic [31:0] ip_memory_write_data,
  input  logic [4:0]  ip_dest_reg,
  input  logic        ip_zero,
  input  logic        ip_MemtoReg,
  input  logic        ip_RegWrite,
  input  logic        ip_read_en,
  input  logic        ip_write_en,
  input  logic        ip_branch,
  output logic        op_branch_taken,
  output logic [7:0]  op_branch_target,
  output logic        op_stall,
  output logic [31:0] op_read_data,
  output logic [31:0] op_ALU_result,
  output logic [4:0]  op_dest_reg,
  output logic        op_MemtoReg,
  output logic        op_RegWrite,
  output logic        op_misaligned
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state_r, next_state_s;
  logic [3:0]    cnt_r, next_cnt_s;
  logic          stall_s, complete_s;
  logic          access_s, misaligned_s, ram_we_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   load_data_s;
  logic [31:0]   mem_r [DEPTH];

  assign access_s         = ip_read_en | ip_write_en;
  assign misaligned_s     = access_s & (ip_ALU_result[1:0] != 2'b00);
  assign idx_s            = ip_ALU_result[AW+1:2];
  assign ram_we_s         = complete_s & ip_write_en & ~misaligned_s;
  assign op_branch_taken  = ip_branch & ip_zero;
  assign op_branch_target = ip_Add_result;
  // Reset must silence the stall even while an access is presented in IDLE.
  assign op_stall         = stall_s & reset;

  // Wait-state sequencing: decide stall, completion and the next state/count.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    stall_s      = 1'b0;
    complete_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s && HAS_WAIT) begin
          stall_s      = 1'b1;
          next_state_s = ST_WAIT;
          next_cnt_s   = CNT_INIT;
        end else begin
          complete_s = access_s;
        end
      end
      ST_WAIT: begin
        if (cnt_r != 4'd0) begin
          stall_s    = 1'b1;
          next_cnt_s = cnt_r - 4'd1;
        end else begin
          complete_s   = 1'b1;
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = 4'd0;
      end
    endcase
  end

  // Load data: read-before-write, zero for store-only and misaligned accesses.
  always_comb begin
    load_data_s = 32'd0;
    if (ip_read_en && !misaligned_s) begin
      load_data_s = mem_r[idx_s];
    end else begin
      load_data_s = 32'd0;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Data RAM write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      mem_r[idx_s] <= ip_memory_write_data;
    end
  end

  // MEM/WB pipeline register; stalled cycles insert a bubble and hold data fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_read_data  <= 32'd0;
      op_ALU_result <= 32'd0;
      op_dest_reg   <= 5'd0;
      op_MemtoReg   <= 1'b0;
      op_RegWrite   <= 1'b0;
      op_misaligned <= 1'b0;
    end else if (stall_s) begin
      op_MemtoReg   <= 1'b0;
      op_RegWrite   <= 1'b0;
      op_misaligned <= 1'b0;
    end else begin
      op_read_data  <= load_data_s;
      op_ALU_result <= ip_ALU_result;
      op_dest_reg   <= ip_dest_reg;
      op_MemtoReg   <= ip_MemtoReg;
      op_RegWrite   <= ip_RegWrite;
      op_misaligned <= misaligned_s;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: three instances with WAIT_STATES 0, 2 and 3 share
// the input bus; each has its own reset so only the one under test is active.
module tb_memory_stage;

  logic        clock;
  logic        rst [3];
  logic [31:0] alu;
  logic [7:0]  add;
  logic [31:0] wdata;
  logic [4:0]  dest;
  logic        zero, m2r, rw, re, we, br;

  logic        o_taken [3];
  logic [7:0]  o_target [3];
  logic        o_stall [3];
  logic [31:0] o_rd [3];
  logic [31:0] o_alu [3];
  logic [4:0]  o_dest [3];
  logic        o_m2r [3];
  logic        o_rw [3];
  logic        o_mis [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_stage #(.DEPTH(256), .WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
      .clock(clock), .reset(rst[g]),
      .ip_ALU_result(alu), .ip_Add_result(add), .ip_memory_write_data(wdata),
      .ip_dest_reg(dest), .ip_zero(zero), .ip_MemtoReg(m2r), .ip_RegWrite(rw),
      .ip_read_en(re), .ip_write_en(we), .ip_branch(br),
      .op_branch_taken(o_taken[g]), .op_branch_target(o_target[g]),
      .op_stall(o_stall[g]), .op_read_data(o_rd[g]), .op_ALU_result(o_alu[g]),
      .op_dest_reg(o_dest[g]), .op_MemtoReg(o_m2r[g]), .op_RegWrite(o_rw[g]),
      .op_misaligned(o_mis[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] ds,
                        input logic mr, input logic rwr);
    re = r; we = w; alu = a; wdata = d; dest = ds; m2r = mr; rw = rwr;
    br = 1'b0; zero = 1'b0; add = 8'h00;
  endtask

  initial begin
    rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick; tick;
    chk("reset_rd", o_rd[0], 32'h0);
    chk("reset_alu", o_alu[0], 32'h0);
    chk("reset_rw", {31'd0, o_rw[0]}, 32'h0);
    chk("reset_stall", {31'd0, o_stall[0]}, 32'h0);

    // ---- WAIT_STATES = 0 ----
    rst[0] = 1'b1;
    set_in(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    #1 chk("ws0_store_stall", {31'd0, o_stall[0]}, 32'h0);
    tick;
    chk("ws0_store_rd", o_rd[0], 32'h0);
    chk("ws0_store_alu", o_alu[0], 32'h10);
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1);
    #1 chk("ws0_load_stall", {31'd0, o_stall[0]}, 32'h0);
    tick;
    chk("ws0_load_rd", o_rd[0], 32'hDEADBEEF);
    chk("ws0_load_dest", {27'd0, o_dest[0]}, 32'd5);
    chk("ws0_load_rw", {31'd0, o_rw[0]}, 32'd1);
    chk("ws0_load_m2r", {31'd0, o_m2r[0]}, 32'd1);

    set_in(1'b0, 1'b1, 32'h13, 32'h1234, 5'd0, 1'b0, 1'b0);
    tick;
    chk("mis_store_flag", {31'd0, o_mis[0]}, 32'd1);
    chk("mis_store_rd", o_rd[0], 32'h0);
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 5'd6, 1'b1, 1'b1);
    tick;
    chk("mis_after_load", o_rd[0], 32'hDEADBEEF);
    chk("mis_after_flag", {31'd0, o_mis[0]}, 32'd0);
    set_in(1'b1, 1'b0, 32'h12, 32'h0, 5'd6, 1'b1, 1'b1);
    tick;
    chk("mis_load_rd", o_rd[0], 32'h0);
    chk("mis_load_flag", {31'd0, o_mis[0]}, 32'd1);

    set_in(1'b0, 1'b1, 32'h400, 32'h55, 5'd0, 1'b0, 1'b0);
    tick;
    set_in(1'b1, 1'b0, 32'h000, 32'h0, 5'd2, 1'b1, 1'b1);
    tick;
    chk("wrap_load", o_rd[0], 32'h55);

    set_in(1'b1, 1'b1, 32'h10, 32'h77, 5'd4, 1'b1, 1'b1);
    tick;
    chk("rmw_old_data", o_rd[0], 32'hDEADBEEF);
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1, 1'b1);
    tick;
    chk("rmw_new_data", o_rd[0], 32'h77);

    set_in(1'b0, 1'b0, 32'hCAFE, 32'h0, 5'd9, 1'b0, 1'b1);
    tick;
    chk("nonacc_rd", o_rd[0], 32'h0);
    chk("nonacc_alu", o_alu[0], 32'hCAFE);
    chk("nonacc_dest", {27'd0, o_dest[0]}, 32'd9);

    br = 1'b1; zero = 1'b1; add = 8'h3C;
    #1;
    chk("br_taken", {31'd0, o_taken[0]}, 32'd1);
    chk("br_target", {24'd0, o_target[0]}, 32'h3C);
    chk("br_stall", {31'd0, o_stall[0]}, 32'd0);
    zero = 1'b0;
    #1 chk("br_not_taken", {31'd0, o_taken[0]}, 32'd0);

    // ---- WAIT_STATES = 2 ----
    rst[0] = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1 rst[1] = 1'b1;
    set_in(1'b0, 1'b1, 32'h20, 32'h11223344, 5'd3, 1'b0, 1'b0);
    #1 chk("ws2_st_stall0", {31'd0, o_stall[1]}, 32'd1);
    tick;
    chk("ws2_st_stall1", {31'd0, o_stall[1]}, 32'd1);
    tick;
    chk("ws2_st_stall2", {31'd0, o_stall[1]}, 32'd0);
    tick;
    set_in(1'b1, 1'b0, 32'h20, 32'h0, 5'd7, 1'b1, 1'b1);
    #1 chk("ws2_ld_stall0", {31'd0, o_stall[1]}, 32'd1);
    tick;
    chk("ws2_ld_stall1", {31'd0, o_stall[1]}, 32'd1);
    chk("ws2_bubble_rw", {31'd0, o_rw[1]}, 32'd0);
    chk("ws2_bubble_m2r", {31'd0, o_m2r[1]}, 32'd0);
    chk("ws2_bubble_dest", {27'd0, o_dest[1]}, 32'd3);
    tick;
    chk("ws2_ld_stall2", {31'd0, o_stall[1]}, 32'd0);
    chk("ws2_ld_rw_pending", {31'd0, o_rw[1]}, 32'd0);
    tick;
    chk("ws2_ld_rd", o_rd[1], 32'h11223344);
    chk("ws2_ld_rw", {31'd0, o_rw[1]}, 32'd1);
    chk("ws2_ld_dest", {27'd0, o_dest[1]}, 32'd7);

    // ---- WAIT_STATES = 3: reset mid-WAIT abandons the store ----
    rst[1] = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1 rst[2] = 1'b1;
    set_in(1'b0, 1'b1, 32'h8, 32'h5555, 5'd0, 1'b0, 1'b0);
    tick; tick; tick; tick;
    chk("ws3_prior_alu", o_alu[2], 32'h8);
    set_in(1'b0, 1'b1, 32'h8, 32'hAAAA, 5'd0, 1'b0, 1'b0);
    tick; tick;
    chk("ws3_wait2_stall", {31'd0, o_stall[2]}, 32'd1);
    rst[2] = 1'b0;
    #1;
    chk("ws3_rst_stall", {31'd0, o_stall[2]}, 32'd0);
    chk("ws3_rst_alu", o_alu[2], 32'h0);
    set_in(1'b1, 1'b0, 32'h8, 32'h0, 5'd1, 1'b1, 1'b1);
    tick;
    rst[2] = 1'b1;
    #1 chk("ws3_re_stall0", {31'd0, o_stall[2]}, 32'd1);
    tick;
    chk("ws3_re_stall1", {31'd0, o_stall[2]}, 32'd1);
    tick;
    chk("ws3_re_stall2", {31'd0, o_stall[2]}, 32'd1);
    tick;
    chk("ws3_re_stall3", {31'd0, o_stall[2]}, 32'd0);
    tick;
    chk("ws3_re_rd", o_rd[2], 32'h5555);
    chk("ws3_re_rw", {31'd0, o_rw[2]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
